// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
// Shared definitions for blocks that drive the 64-bit execute-stage ALU.
// Contents:
//   ALU_WIDTH              - datapath width of the shared ALU
//   SEL_* constants        - 5-bit ALU select codes, func field in [4:2]
//   INV_A / INV_B          - operand inversion bits [0] / [1], OR-able into a select
//   state_t                - sequencer states used by alu_mul_seq
package alu_ctrl_pkg;

    localparam int ALU_WIDTH = 64;

    // ALU function codes live in sel[4:2]; sel[1:0] invert the operands.
    localparam logic [4:0] SEL_NOP = 5'b00000;
    localparam logic [4:0] SEL_OR  = 5'b00100;
    localparam logic [4:0] SEL_AND = 5'b01000;
    localparam logic [4:0] SEL_XOR = 5'b01100;
    localparam logic [4:0] SEL_ADD = 5'b10000;
    localparam logic [4:0] SEL_SHR = 5'b10100;
    localparam logic [4:0] SEL_SHL = 5'b11000;
    localparam logic [4:0] INV_A   = 5'b00001;
    localparam logic [4:0] INV_B   = 5'b00010;

    typedef enum logic [2:0] {
        IDLE,
        ADD,
        SHL,
        SHR,
        DONE
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq
// Multi-cycle unsigned WIDTH x WIDTH multiplier that borrows the shared ALU.
// It runs shift-add, issuing one ALU operation (ADD, SHL or SHR) per cycle,
// and returns the low WIDTH bits of the product plus an overflow flag.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   start, op_a, op_b   - request and operands, accepted only in IDLE
//   busy, done          - status: busy outside IDLE, done pulses one cycle
//   product, ovf        - result, updated at the end of the DONE cycle and held
//   alu_a, alu_b        - ALU operands (combinational from state/registers)
//   alu_cin, alu_sel    - ALU carry-in (always 0) and function select
//   alu_out, alu_cout   - ALU combinational result and carry-out
module alu_mul_seq
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             ovf,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    output logic [4:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_cout
);

    state_t             state_q,   state_d;
    logic [WIDTH-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0]   mplier_q,  mplier_d;
    logic [WIDTH-1:0]   acc_q,     acc_d;
    logic               ovf_r_q,   ovf_r_d;
    logic [CNT_W-1:0]   iter_q,    iter_d;
    logic [WIDTH-1:0]   product_q, product_d;
    logic               ovf_q,     ovf_d;

    // ALU drive depends only on the current state and registers, never on
    // alu_out, so the loop through the external combinational ALU stays open.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = SEL_NOP;
        unique case (state_q)
            ADD: begin
                alu_a   = acc_q;
                alu_b   = mcand_q;
                alu_sel = SEL_ADD;
            end
            SHL: begin
                alu_a   = mcand_q;
                alu_b   = WIDTH'(1);
                alu_sel = SEL_SHL;
            end
            SHR: begin
                alu_a   = mplier_q;
                alu_b   = WIDTH'(1);
                alu_sel = SEL_SHR;
            end
            default: begin
            end
        endcase
    end

    // Next-state and register updates. Overflow is tracked two ways: a carry
    // out of an accumulate, or a multiplicand bit shifted out of the top while
    // multiplier bits that would still use it remain.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        ovf_r_d   = ovf_r_q;
        iter_d    = iter_q;
        product_d = product_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = '0;
                    ovf_r_d  = 1'b0;
                    iter_d   = '0;
                    if (op_b == '0) begin
                        state_d = DONE;
                    end else if (op_b[0]) begin
                        state_d = ADD;
                    end else begin
                        state_d = SHL;
                    end
                end
            end
            ADD: begin
                acc_d   = alu_out;
                ovf_r_d = ovf_r_q | alu_cout;
                state_d = SHL;
            end
            SHL: begin
                mcand_d = alu_out;
                if (mcand_q[WIDTH-1] && ((mplier_q >> 1) != '0)) begin
                    ovf_r_d = 1'b1;
                end
                state_d = SHR;
            end
            SHR: begin
                mplier_d = alu_out;
                iter_d   = iter_q + CNT_W'(1);
                if ((alu_out == '0) || (iter_q == CNT_W'(WIDTH - 1))) begin
                    state_d = DONE;
                end else if (alu_out[0]) begin
                    state_d = ADD;
                end else begin
                    state_d = SHL;
                end
            end
            DONE: begin
                product_d = acc_q;
                ovf_d     = ovf_r_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            ovf_r_q   <= 1'b0;
            iter_q    <= '0;
            product_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            ovf_r_q   <= ovf_r_d;
            iter_q    <= iter_d;
            product_q <= product_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign product = product_q;
    assign ovf     = ovf_q;
    assign alu_cin = 1'b0;

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq
// Directed bench for alu_mul_seq with a behavioural model of the shared
// combinational ALU wired to the alu_* ports.
module tb_alu_mul_seq;
    import alu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] op_a = '0;
    logic [63:0] op_b = '0;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic        ovf;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic        alu_cin;
    logic [4:0]  alu_sel;
    logic [63:0] alu_out;
    logic        alu_cout;

    int total_checks = 0;
    int bad_checks   = 0;

    logic [4:0] sel_log [0:255];
    int         sel_count;

    alu_mul_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .ovf      (ovf),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_cin  (alu_cin),
        .alu_sel  (alu_sel),
        .alu_out  (alu_out),
        .alu_cout (alu_cout)
    );

    // 10 time-unit clock.
    always #5 clk = ~clk;

    // Behavioural model of the shared combinational ALU.
    logic [63:0] eff_a;
    logic [63:0] eff_b;
    logic [64:0] sum;
    always_comb begin
        eff_a    = alu_sel[0] ? ~alu_a : alu_a;
        eff_b    = alu_sel[1] ? ~alu_b : alu_b;
        sum      = {1'b0, eff_a} + {1'b0, eff_b} + {64'd0, alu_cin};
        alu_out  = '0;
        alu_cout = 1'b0;
        case (alu_sel[4:2])
            3'd1: alu_out = eff_a | eff_b;
            3'd2: alu_out = eff_a & eff_b;
            3'd3: alu_out = eff_a ^ eff_b;
            3'd4: begin
                alu_out  = sum[63:0];
                alu_cout = sum[64];
            end
            3'd5: alu_out = eff_a >> eff_b[5:0];
            3'd6: alu_out = eff_a << eff_b[5:0];
            default: begin
            end
        endcase
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Launches one multiply, follows it to done, checks latency and result.
    // With spam set, start stays high with changing operands while busy.
    task automatic applyStimulus(input string tag, input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] exp_prod, input logic exp_ovf,
                                 input int exp_lat, input bit spam);
        int   lat;
        logic busy_ok;
        logic busy_at_done;
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (spam) begin
            op_a = ~a;
            op_b = b ^ 64'h5;
        end else begin
            start = 1'b0;
        end
        lat          = 0;
        busy_ok      = 1'b1;
        busy_at_done = 1'b0;
        sel_count    = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (sel_count < 256) begin
                sel_log[sel_count] = alu_sel;
                sel_count++;
            end
            if (done) begin
                lat          = k;
                busy_at_done = busy;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (spam) begin
                op_a  = op_a + 64'd3;
                op_b  = op_b + 64'd11;
                start = 1'b1;
            end
        end
        if (lat == 0) begin
            checkOutput({tag, " timeout"}, 64'd0, 64'd1);
        end else begin
            checkOutput({tag, " latency"}, 64'(lat), 64'(exp_lat));
            checkOutput({tag, " busy during run"}, 64'(busy_ok), 64'd1);
            checkOutput({tag, " busy in done"}, 64'(busy_at_done), 64'd1);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput({tag, " product"}, product, exp_prod);
        checkOutput({tag, " ovf"}, 64'(ovf), 64'(exp_ovf));
        checkOutput({tag, " done after"}, 64'(done), 64'd0);
        checkOutput({tag, " busy after"}, 64'(busy), 64'd0);
    endtask

    logic [4:0] exp_seq [0:8];
    logic       seen_done;

    initial begin
        exp_seq = '{SEL_ADD, SEL_SHL, SEL_SHR, SEL_SHL, SEL_SHR, SEL_ADD, SEL_SHL, SEL_SHR, SEL_NOP};

        // Reset state.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset product", product, 64'd0);
        checkOutput("reset ovf", 64'(ovf), 64'd0);
        checkOutput("reset alu_sel", 64'(alu_sel), 64'd0);
        checkOutput("reset alu_a", alu_a, 64'd0);
        checkOutput("reset alu_b", alu_b, 64'd0);
        checkOutput("reset alu_cin", 64'(alu_cin), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 3 x 5 with full ALU select sequence.
        applyStimulus("3x5", 64'd3, 64'd5, 64'd15, 1'b0, 9, 1'b0);
        for (int i = 0; i < 9; i++) begin
            checkOutput($sformatf("3x5 seq%0d", i), 64'(sel_log[i]), 64'(exp_seq[i]));
        end

        // Zero multiplier goes straight to DONE.
        applyStimulus("bzero", 64'h1234, 64'd0, 64'd0, 1'b0, 1, 1'b0);
        checkOutput("bzero alu_sel", 64'(sel_log[0]), 64'(SEL_NOP));

        // Multiplicand bit lost off the top by SHL.
        applyStimulus("shl ovf", 64'h8000_0000_0000_0000, 64'd2, 64'd0, 1'b1, 6, 1'b0);
        // Largest in-range power-of-two product.
        applyStimulus("2^63", 64'h0000_0001_0000_0000, 64'h0000_0000_8000_0000,
                      64'h8000_0000_0000_0000, 1'b0, 66, 1'b0);
        // Worst-case latency.
        applyStimulus("all ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                      64'd1, 1'b1, 193, 1'b0);
        // Zero multiplicand runs the full sequence.
        applyStimulus("azero", 64'd0, 64'd5, 64'd0, 1'b0, 9, 1'b0);
        // Start re-asserted while busy and during DONE is ignored.
        applyStimulus("spam 7x6", 64'd7, 64'd6, 64'd42, 1'b0, 9, 1'b1);

        // Reset in the 4th cycle of a run discards it.
        @(negedge clk);
        op_a  = 64'd9;
        op_b  = 64'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midreset busy", 64'(busy), 64'd0);
        checkOutput("midreset product", product, 64'd0);
        checkOutput("midreset ovf", 64'(ovf), 64'd0);
        checkOutput("midreset done", 64'(done), 64'd0);
        checkOutput("midreset alu_sel", 64'(alu_sel), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        checkOutput("midreset no done", 64'(seen_done), 64'd0);
        applyStimulus("9x9", 64'd9, 64'd9, 64'd81, 1'b0, 11, 1'b0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
Multi-cycle sequencer that computes an unsigned 64x64 product (low 64 bits plus overflow flag) by time-multiplexing the shared 64-bit ALU. It runs a shift-add algorithm and issues exactly one ALU operation per cycle: ADD, shift-left or shift-right. It sits beside the ALU in the execute stage. It drives the ALU operand, carry-in and select inputs, and reads back the ALU result and carry-out.

Parameters:
WIDTH, 64, operand/ALU width; must equal ALU width (only 64 supported)
CNT_W, 7, width of iteration counter (must hold WIDTH)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
start  in  1  request; sampled only in IDLE
op_a  in  64  multiplicand, latched on accepted start
op_b  in  64  multiplier, latched on accepted start
busy  out  1  high from cycle after accepted start through DONE
done  out  1  one-cycle pulse; product/ovf valid
product  out  64  low 64 bits of op_a*op_b; held until next accepted start
ovf  out  1  true product >= 2^64; held with product
alu_a  out  64  ALU operand A
alu_b  out  64  ALU operand B
alu_cin  out  1  ALU carry-in (always 0)
alu_sel  out  5  ALU select: [0] invert A, [1] invert B, [4:2] function
alu_out  in  64  ALU combinational result, same cycle
alu_cout  in  1  ALU carry-out, same cycle

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n); it is sampled only on a rising clk edge.
- ALU encodings:
  - ADD = 5'b10000 (func 4)
  - SHR = 5'b10100 (func 5, shift amount alu_b[5:0])
  - SHL = 5'b11000 (func 6)
  - NOP = 5'b00000 (func 0, ALU outputs zero)
- Internal registers: mcand, mplier, acc (64 bits each), ovf_r, iter (CNT_W bits), state.
- States:
  - IDLE: alu_sel=NOP, alu_a=alu_b=0. On start: mcand<=op_a, mplier<=op_b, acc<=0, ovf_r<=0, iter<=0.
    - next = DONE if op_b==0; ADD if op_b[0]; else SHL.
  - ADD: alu_a=acc, alu_b=mcand, sel=ADD.
    - acc<=alu_out; ovf_r<=ovf_r|alu_cout; next SHL.
  - SHL: alu_a=mcand, alu_b=1, sel=SHL.
    - mcand<=alu_out.
    - If mcand[63]==1 and (mplier>>1)!=0 then ovf_r<=1.
    - next SHR.
  - SHR: alu_a=mplier, alu_b=1, sel=SHR.
    - mplier<=alu_out; iter<=iter+1.
    - next = DONE if alu_out==0 or iter==WIDTH-1; ADD if alu_out[0]; else SHL.
  - DONE: done=1; product<=acc; ovf<=ovf_r; alu_sel=NOP; next IDLE.
- Status outputs:
  - busy = (state != IDLE).
  - done is high only in DONE, exactly one cycle.
  - product/ovf update on the DONE edge and hold otherwise.
- Latency: a start accepted at edge T0 gives done high during cycle T0+N+1.
  - N = 3 x popcount-free iteration count, minus skipped ADDs.
  - Each iteration is 2 cycles, plus 1 if the multiplier bit is set.
  - Iterations = index of the highest set bit of op_b, plus 1.
  - Worst case (op_b = all ones): 192 ALU cycles, then DONE.
- Boundary conditions:
  - start while busy: ignored; latched operands are unaffected.
  - start in the DONE cycle: ignored; the next start is accepted in IDLE.
  - op_b==0: IDLE->DONE directly; product=0, ovf=0, done in cycle T0+1.
  - op_a==0: runs full sequence; product=0, ovf=0.
  - rst_n low in any state: next edge forces IDLE and clears all of the following:
    - outputs: product, ovf, done, busy
    - ALU drive: alu_a, alu_b, alu_sel, alu_cin
    - internal: mcand, mplier, acc, iter
    - In-flight result is discarded.
- ALU outputs are combinational from state and registers. The ALU must be purely combinational; no registered ALU path is supported.

Decomposition:
- Package alu_ctrl_pkg:
  - ALU select constants (SEL_NOP, SEL_OR, SEL_AND, SEL_XOR, SEL_ADD, SEL_SHR, SEL_SHL, INV_A, INV_B)
  - state enum (IDLE, ADD, SHL, SHR, DONE)
  - ALU_WIDTH=64
- No sub-module. The bench instantiates the existing ALU and wires it to the alu_* ports.

Test Plan:
- Reset then start with op_a=3, op_b=5 -> sequence ADD,SHL,SHR,SHL,SHR,ADD,SHL,SHR; done at T0+9; product=15; ovf=0; busy high T0+1..T0+9.
- op_a=0x1234, op_b=0 -> done at T0+1; product=0; ovf=0; alu_sel stays 0.
- op_a=2^63, op_b=2 -> product=0, ovf=1 (lost bit via SHL rule). Then op_a=2^32, op_b=2^31 -> product=2^63, ovf=0.
- op_a=0xFFFF_FFFF_FFFF_FFFF, op_b=0xFFFF_FFFF_FFFF_FFFF -> 192 ALU cycles, done at T0+193; product=1; ovf=1.
- Re-assert start with different operands every cycle while busy for op_a=7, op_b=6 -> ignored; product=42.
- rst_n low for one cycle mid-run (op_a=9, op_b=9, 4th cycle) -> IDLE next edge; busy=0; product=0; no done pulse. Then a new start with op_a=9, op_b=9 gives product=81.
